cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
Frame-level controller placed in front of CNN_TOP.
- Accepts an 8-bit pixel stream with valid/ready and a start-of-frame flag from the camera/DMA side.
- Issues the one-cycle start pulse and the gated pixel stream CNN_TOP expects, then waits for final_result_valid with a timeout.
- Hands the 48-bit lane result downstream through a valid/ready register, and recovers CNN_TOP via a local reset on errors.

Parameters:
IMG_WIDTH, 32, pixels per line
IMG_HEIGHT, 32, lines per frame (frame = IMG_WIDTH*IMG_HEIGHT = 1024 beats)
RES_W, 48, CNN result width
TIMEOUT_CYC, 8192, max cycles in WAIT_RES before abort
CNN_RST_CYC, 4, cycles cnn_rst is held after an abort

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
enable  in  1  1 = accept new frames; sampled only in IDLE
s_valid  in  1  upstream pixel valid
s_sof  in  1  first pixel of frame, qualified by s_valid
s_data  in  8  pixel
s_ready  out  1  upstream ready
cnn_rst  out  1  active-high reset to CNN_TOP
cnn_start  out  1  start_signal to CNN_TOP
cnn_pixel_valid  out  1  pixel_valid to CNN_TOP
cnn_pixel_in  out  8  pixel_in to CNN_TOP
cnn_result_valid  in  1  final_result_valid from CNN_TOP
cnn_result  in  RES_W  final_lane_result (signed)
m_valid  out  1  result valid
m_data  out  RES_W  captured result (signed)
m_ready  in  1  downstream ready
busy  out  1  state != IDLE
err_timeout  out  1  sticky; cleared by reset only
err_sync  out  1  sticky; early SOF inside frame
frame_cnt  out  16  frames completed (wraps 0xFFFF->0)

Behaviour:
- Reset (rst=0, async):
  - All outputs 0 except cnn_rst=1.
  - State = RECOVER with counter loaded to CNN_RST_CYC; cnn_rst stays 1 for CNN_RST_CYC cycles after rst deasserts, then IDLE.
- Beat accepted = s_valid & s_ready at posedge.
- IDLE:
  - s_ready = ~s_sof; non-SOF beats are drained and discarded.
  - If enable & s_valid & s_sof -> START; the SOF beat is not consumed here.
- START:
  - s_ready=0; cnn_start=1 for exactly this cycle.
  - Clear pix_cnt. -> STREAM.
- STREAM:
  - s_ready=1.
  - Each accepted beat is registered: cnn_pixel_valid=1 and cnn_pixel_in=s_data on the next cycle (1-cycle latency). Otherwise cnn_pixel_valid=0; gaps are allowed.
  - pix_cnt increments per beat. On the beat with pix_cnt == IMG_WIDTH*IMG_HEIGHT-1 -> WAIT_RES.
  - Accepted beat with s_sof=1 and pix_cnt != 0: beat dropped (no cnn_pixel_valid), err_sync=1 -> RECOVER.
- WAIT_RES:
  - s_ready=0; tmo_cnt increments each cycle.
  - cnn_result_valid=1: m_data <= cnn_result, m_valid <= 1, frame_cnt++ -> HOLD.
  - tmo_cnt == TIMEOUT_CYC-1 without result: err_timeout=1, no m_valid -> RECOVER.
  - If result and timeout coincide in the same cycle, the result wins.
- HOLD:
  - s_ready=0; m_valid and m_data stable until m_ready=1.
  - On handshake: m_valid=0 next cycle -> IDLE.
  - cnn_result_valid pulses in HOLD are ignored.
- RECOVER:
  - cnn_rst=1 and s_ready=0 for CNN_RST_CYC cycles.
  - pix_cnt and tmo_cnt cleared -> IDLE. Partial frames are never resumed.
- enable=0 outside IDLE has no effect; the current frame completes.
- frame_cnt counts only results delivered to m_data.
- cnn_start and cnn_pixel_valid are never high in the same cycle.

Test Plan:
- Nominal: enable=1, 1024 beats of 100+(x^y) with SOF on beat 0, no gaps; model returns result 0x0000_0012_3456 after 300 cycles -> cnn_start one pulse, cnn_pixel_valid exactly 1024 cycles, m_valid with m_data=0x123456, frame_cnt=1, m_ready held 0 for 10 cycles keeps m_data stable.
- Gapped stream: s_valid toggled randomly at 50% -> still exactly 1024 cnn_pixel_valid pulses, pixel order identical, each pixel one cycle after acceptance.
- Pre-frame junk: 5 beats with s_sof=0 in IDLE -> all drained (s_ready=1), no cnn_start; the following SOF beat starts the frame.
- Early SOF: second s_sof at pix_cnt=500 -> err_sync=1, cnn_rst high 4 cycles, back to IDLE, no m_valid, frame_cnt unchanged.
- Timeout: model never asserts result -> err_timeout=1 exactly 8192 cycles after entering WAIT_RES, cnn_rst for 4 cycles; the next good frame then completes with frame_cnt=1.
- Async reset mid-STREAM at pix_cnt=300 -> outputs clear immediately, cnn_rst=1, err flags 0, frame_cnt=0; a new full frame after release passes.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_frame_sequencer
//
// Frame-level controller in front of CNN_TOP. It takes a camera/DMA pixel
// stream (valid/ready + start-of-frame flag), turns one full frame into the
// start pulse and gated pixel stream CNN_TOP expects, waits for the final
// result with a timeout, and then offers that result downstream through a
// valid/ready holding register. On any framing error or timeout, CNN_TOP is
// held in its local reset for a fixed number of cycles before the next frame.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   enable              accept new frames (looked at only while idle)
//   s_valid/s_sof/s_data/s_ready   upstream pixel stream
//   cnn_rst             active-high reset to CNN_TOP
//   cnn_start           one-cycle start_signal to CNN_TOP
//   cnn_pixel_valid/cnn_pixel_in   registered pixel stream to CNN_TOP
//   cnn_result_valid/cnn_result    final result from CNN_TOP
//   m_valid/m_data/m_ready         downstream result handshake
//   busy                controller is not idle
//   err_timeout         sticky: no result within TIMEOUT_CYC cycles
//   err_sync            sticky: SOF seen inside a frame
//   frame_cnt           number of results delivered (wrapping)
// ---------------------------------------------------------------------------
module cnn_frame_sequencer #(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int RES_W       = 48,
    parameter int TIMEOUT_CYC = 8192,
    parameter int CNN_RST_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    // upstream pixel stream
    input  logic                    s_valid,
    input  logic                    s_sof,
    input  logic [7:0]              s_data,
    output logic                    s_ready,
    // CNN_TOP control / data
    output logic                    cnn_rst,
    output logic                    cnn_start,
    output logic                    cnn_pixel_valid,
    output logic [7:0]              cnn_pixel_in,
    input  logic                    cnn_result_valid,
    input  logic signed [RES_W-1:0] cnn_result,
    // downstream result
    output logic                    m_valid,
    output logic signed [RES_W-1:0] m_data,
    input  logic                    m_ready,
    // status
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_sync,
    output logic [15:0]             frame_cnt
);

    localparam int FRAME = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RC_W  = $clog2(CNN_RST_CYC + 1);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [RC_W-1:0]  RC_INIT  = RC_W'(CNN_RST_CYC);
    localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_RES,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t                    state_q, state_d;
    logic [PIX_W-1:0]          pix_cnt_q;
    logic [TMO_W-1:0]          tmo_cnt_q;
    logic [RC_W-1:0]           rc_cnt_q;

    logic                      cnn_rst_q;
    logic                      cnn_start_q;
    logic                      pix_vld_q;
    logic [7:0]                pix_dat_q;
    logic                      m_valid_q;
    logic signed [RES_W-1:0]   m_data_q;
    logic                      busy_q;
    logic                      err_timeout_q;
    logic                      err_sync_q;
    logic [15:0]               frame_cnt_q;

    // Upstream ready depends on the current SOF flag while idle: non-SOF
    // junk is drained, but the SOF beat is held so STREAM can consume it.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_IDLE:   s_ready = ~s_sof;
            S_STREAM: s_ready = 1'b1;
            default:  s_ready = 1'b0;
        endcase
    end

    logic beat_acc;
    logic sof_err;
    logic last_beat;
    logic tmo_hit;

    assign beat_acc  = s_valid & s_ready;
    // The SOF beat itself arrives with pix_cnt == 0; any later SOF is a
    // framing slip and aborts the frame without forwarding that beat.
    assign sof_err   = (state_q == S_STREAM) & beat_acc & s_sof & (pix_cnt_q != '0);
    assign last_beat = (state_q == S_STREAM) & beat_acc & ~sof_err & (pix_cnt_q == PIX_LAST);
    // A result arriving on the last timeout cycle takes priority.
    assign tmo_hit   = (state_q == S_WAIT_RES) & ~cnn_result_valid & (tmo_cnt_q == TMO_LAST);

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable && s_valid && s_sof) state_d = S_START;
            end
            S_START: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (sof_err)        state_d = S_RECOVER;
                else if (last_beat) state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (cnn_result_valid) state_d = S_HOLD;
                else if (tmo_hit)     state_d = S_RECOVER;
            end
            S_HOLD: begin
                if (m_ready) state_d = S_IDLE;
            end
            S_RECOVER: begin
                if (rc_cnt_q <= RC_ONE) state_d = S_IDLE;
            end
            default: state_d = S_RECOVER;
        endcase
    end

    // State, counters and registered outputs. Reset parks the FSM in
    // RECOVER so CNN_TOP sees a clean reset window after rst releases.
    // busy is registered from the next state, so it stays low through
    // reset and rises one cycle into the post-reset recovery window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_RECOVER;
            pix_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            rc_cnt_q      <= RC_INIT;
            cnn_rst_q     <= 1'b1;
            cnn_start_q   <= 1'b0;
            pix_vld_q     <= 1'b0;
            pix_dat_q     <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_sync_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            cnn_rst_q   <= (state_d == S_RECOVER);
            cnn_start_q <= (state_d == S_START);
            pix_vld_q   <= 1'b0;

            case (state_q)
                S_START: begin
                    pix_cnt_q <= '0;
                end
                S_STREAM: begin
                    if (beat_acc) begin
                        if (sof_err) begin
                            err_sync_q <= 1'b1;
                            rc_cnt_q   <= RC_INIT;
                        end else begin
                            pix_vld_q <= 1'b1;
                            pix_dat_q <= s_data;
                            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                            if (last_beat) tmo_cnt_q <= '0;
                        end
                    end
                end
                S_WAIT_RES: begin
                    if (cnn_result_valid) begin
                        m_data_q    <= cnn_result;
                        m_valid_q   <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        tmo_cnt_q   <= '0;
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        rc_cnt_q      <= RC_INIT;
                        tmo_cnt_q     <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                S_HOLD: begin
                    // Late or duplicate result pulses are ignored here.
                    if (m_ready) m_valid_q <= 1'b0;
                end
                S_RECOVER: begin
                    if (rc_cnt_q != '0) rc_cnt_q <= rc_cnt_q - RC_ONE;
                    // Partial frames are abandoned, never resumed.
                    pix_cnt_q <= '0;
                    tmo_cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign cnn_rst         = cnn_rst_q;
    assign cnn_start       = cnn_start_q;
    assign cnn_pixel_valid = pix_vld_q;
    assign cnn_pixel_in    = pix_dat_q;
    assign m_valid         = m_valid_q;
    assign m_data          = m_data_q;
    assign busy            = busy_q;
    assign err_timeout     = err_timeout_q;
    assign err_sync        = err_sync_q;
    assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for cnn_frame_sequencer: directed frames with a CNN_TOP stand-in,
// expected pixels/results queued at issue time, checked by a monitor.
// ---------------------------------------------------------------------------
module tb_cnn_frame_sequencer;

    localparam int FRAME   = 1024;
    localparam int RES_W   = 48;
    localparam logic [RES_W-1:0] RES_VAL = 48'h0000_0012_3456;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_sof = 1'b0;
    logic [7:0]       s_data = 8'h00;
    logic             s_ready;
    logic             cnn_rst, cnn_start, cnn_pixel_valid;
    logic [7:0]       cnn_pixel_in;
    logic             cnn_result_valid;
    logic [RES_W-1:0] cnn_result;
    logic             m_valid;
    logic [RES_W-1:0] m_data;
    logic             m_ready = 1'b0;
    logic             busy, err_timeout, err_sync;
    logic [15:0]      frame_cnt;

    cnn_frame_sequencer dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data), .s_ready(s_ready),
        .cnn_rst(cnn_rst), .cnn_start(cnn_start),
        .cnn_pixel_valid(cnn_pixel_valid), .cnn_pixel_in(cnn_pixel_in),
        .cnn_result_valid(cnn_result_valid), .cnn_result(cnn_result),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .err_timeout(err_timeout), .err_sync(err_sync),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { logic [7:0] d; int tag; } pix_t;
    pix_t             exp_pix[$];
    logic [RES_W-1:0] exp_res[$];
    int pix_seen = 0;
    int start_seen = 0;

    initial forever begin
        @(negedge clk);
        if (cnn_pixel_valid) begin
            pix_seen++;
            if (exp_pix.size() == 0) begin
                chk("pix_unexpected", 64'(cnn_pixel_in), 64'hFFFF);
            end else begin
                pix_t p;
                p = exp_pix.pop_front();
                chk("pix_data", 64'(cnn_pixel_in), 64'(p.d));
                chk("pix_latency", 64'(cyc), 64'(p.tag + 1));
            end
        end
        if (cnn_start) begin
            start_seen++;
            chk("start_pix_excl", 64'(cnn_pixel_valid), 64'd0);
        end
        if (m_valid && m_ready) begin
            if (exp_res.size() == 0) chk("res_unexpected", 64'(m_data), 64'hFFFF);
            else chk("res_data", 64'(m_data), 64'(exp_res.pop_front()));
        end
    end

    // ---------------- CNN_TOP stand-in ----------------
    bit model_respond = 1'b1;
    bit extra_pulse   = 1'b0;
    int mdl_cnt = 0;
    int mdl_wait = -1;

    initial begin
        cnn_result_valid = 1'b0;
        cnn_result = '0;
        forever begin
            @(negedge clk);
            cnn_result_valid = 1'b0;
            if (cnn_rst) begin
                mdl_cnt = 0;
                mdl_wait = -1;
            end else begin
                if (cnn_start) mdl_cnt = 0;
                if (cnn_pixel_valid) begin
                    mdl_cnt++;
                    if (mdl_cnt == FRAME && model_respond) mdl_wait = 300;
                end
                if (extra_pulse) begin
                    cnn_result_valid = 1'b1;
                    cnn_result = 48'h0000_0000_0BAD;
                    extra_pulse = 1'b0;
                end else if (mdl_wait == 0) begin
                    cnn_result_valid = 1'b1;
                    cnn_result = RES_VAL;
                    mdl_wait = -1;
                end else if (mdl_wait > 0) begin
                    mdl_wait--;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] pix_val(input int i);
        int x, y;
        x = i % 32;
        y = i / 32;
        return 8'(100 + (x ^ y));
    endfunction

    task automatic drive_beat(input logic [7:0] d, input logic sof, input bit push, output int tag);
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (s_ready) begin
                tag = cyc;
                if (push) exp_pix.push_back('{d, cyc});
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("beat_accept_timeout", 64'd0, 64'd1);
        tag = -1;
    endtask

    task automatic drive_frame(input bit gaps, input int sof_at, input int n_beats,
                               input bit expect_res, output int last_tag);
        int tag;
        bit drop;
        last_tag = -1;
        for (int i = 0; i < n_beats; i++) begin
            if (gaps) begin
                s_valid = 1'b0;
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
                    @(posedge clk);
                    #1;
                end
            end
            drop = (sof_at > 0) && (i == sof_at);
            drive_beat(pix_val(i), (i == 0) || drop, !drop, tag);
            last_tag = tag;
            if (tag < 0 || drop) break;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        if (expect_res) exp_res.push_back(RES_VAL);
    endtask

    task automatic wait_result(input int hold, input bit extra, input int exp_frames);
        int w;
        logic [RES_W-1:0] d;
        w = 0;
        while (!m_valid && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("result_arrived", 64'(m_valid), 64'd1);
        if (!m_valid) return;
        d = m_data;
        if (extra) extra_pulse = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_data", 64'(m_data), 64'(d));
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("mvalid_drop", 64'(m_valid), 64'd0);
        chk("idle_after_hs", 64'(busy), 64'd0);
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    endtask

    task automatic count_rst(output int n);
        n = 0;
        while (cnn_rst && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tag, n, ps, ss;
        int fcnt;
        fcnt = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cnn_rst", 64'(cnn_rst), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_start", 64'(cnn_start), 64'd0);
        chk("rst_pvalid", 64'(cnn_pixel_valid), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_errs", 64'({err_timeout, err_sync}), 64'd0);
        chk("rst_fcnt", 64'(frame_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        count_rst(n);
        chk("post_rst_cnn_rst_cycles", 64'(n), 64'd4);

        // enable=0: SOF is neither consumed nor started
        s_valid = 1'b1; s_sof = 1'b1;
        repeat (5) @(negedge clk);
        chk("disabled_no_start", 64'(start_seen), 64'd0);
        chk("disabled_idle", 64'(busy), 64'd0);
        chk("disabled_sof_held", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0;
        enable = 1'b1;

        // Pre-frame junk, then nominal frame
        for (int k = 0; k < 5; k++) drive_beat(8'hA0 + 8'(k), 1'b0, 1'b0, tag);
        chk("junk_no_start", 64'(start_seen), 64'd0);
        chk("junk_no_pix", 64'(pix_seen), 64'd0);
        ps = pix_seen; ss = start_seen;
        drive_frame(1'b0, -1, FRAME, 1'b1, tag);
        fcnt++;
        wait_result(10, 1'b1, fcnt);
        chk("nom_start_pulses", 64'(start_seen - ss), 64'd1);
        chk("nom_pix_count", 64'(pix_seen - ps), 64'(FRAME));

        // Gapped stream; enable drops while waiting for the result
        ps = pix_seen; ss = start_seen;
        drive_frame(1'b1, -1, FRAME, 1'b1, tag);
        enable = 1'b0;
        fcnt++;
        wait_result(0, 1'b0, fcnt);
        enable = 1'b1;
        chk("gap_start_pulses", 64'(start_seen - ss), 64'd1);
        chk("gap_pix_count", 64'(pix_seen - ps), 64'(FRAME));

        // Early SOF at pixel 500
        ps = pix_seen;
        drive_frame(1'b0, 500, FRAME, 1'b0, tag);
        chk("esof_err_sync", 64'(err_sync), 64'd1);
        @(negedge clk);
        count_rst(n);
        chk("esof_cnn_rst_cycles", 64'(n), 64'd4);
        chk("esof_idle", 64'(busy), 64'd0);
        chk("esof_no_mvalid", 64'(m_valid), 64'd0);
        chk("esof_fcnt", 64'(frame_cnt), 64'(fcnt));
        chk("esof_pix_count", 64'(pix_seen - ps), 64'd500);
        chk("esof_sb_empty", 64'(exp_pix.size()), 64'd0);

        // Timeout
        model_respond = 1'b0;
        drive_frame(1'b0, -1, FRAME, 1'b0, tag);
        n = 0;
        while (!err_timeout && n < 9000) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_flag", 64'(err_timeout), 64'd1);
        chk("tmo_cycle", 64'(cyc), 64'(tag + 1 + 8192));
        count_rst(n);
        chk("tmo_cnn_rst_cycles", 64'(n), 64'd4);
        chk("tmo_no_mvalid", 64'(m_valid), 64'd0);
        chk("tmo_fcnt", 64'(frame_cnt), 64'(fcnt));
        model_respond = 1'b1;
        drive_frame(1'b0, -1, FRAME, 1'b1, tag);
        fcnt++;
        wait_result(0, 1'b0, fcnt);
        chk("tmo_flag_sticky", 64'(err_timeout), 64'd1);

        // Async reset mid-stream at pixel 300
        drive_frame(1'b0, -1, 300, 1'b0, tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cnn_rst", 64'(cnn_rst), 64'd1);
        chk("arst_pvalid", 64'(cnn_pixel_valid), 64'd0);
        chk("arst_s_ready", 64'(s_ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_errs", 64'({err_timeout, err_sync}), 64'd0);
        chk("arst_fcnt", 64'(frame_cnt), 64'd0);
        exp_pix.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        count_rst(n);
        chk("arst_cnn_rst_cycles", 64'(n), 64'd4);
        fcnt = 1;
        ps = pix_seen;
        drive_frame(1'b0, -1, FRAME, 1'b1, tag);
        wait_result(0, 1'b0, fcnt);
        chk("arst_pix_count", 64'(pix_seen - ps), 64'(FRAME));

        repeat (5) @(negedge clk);
        chk("final_pix_sb_empty", 64'(exp_pix.size()), 64'd0);
        chk("final_res_sb_empty", 64'(exp_res.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
